// File: rtl/multi_alarm_clk.sv
// multi_alarm_clk: time-of-day clock with several programmable alarms, snooze and ring timeout
module multi_alarm_clk #(
    parameter int NUM_ALARMS  = 4,
    parameter int HOUR_24     = 0,
    parameter int SNOOZE_MINS = 9,
    parameter int RING_SECS   = 60,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          Clock_1Sec,
    input  logic          Reset,
    input  logic          LoadTime,
    input  logic [5:0]    SetSecs,
    input  logic [5:0]    SetMins,
    input  logic [4:0]    SetHours,
    input  logic          Set_AM_PM,
    input  logic          LoadAlm,
    input  logic [AW-1:0] AlmSel,
    input  logic [5:0]    AlarmMinsIn,
    input  logic [4:0]    AlarmHoursIn,
    input  logic          Alarm_AM_PM_In,
    input  logic          AlarmEnIn,
    input  logic          Snooze,
    input  logic          AlarmStop,
    output logic [5:0]    Secs_C,
    output logic [5:0]    Mins_C,
    output logic [4:0]    Hours_C,
    output logic          AM_PM,
    output logic          Alarm,
    output logic [AW-1:0] AlarmSrc,
    output logic          Snoozing
);
    localparam int SNZ_LEN = SNOOZE_MINS * 60;
    localparam int SW = $clog2(SNZ_LEN + 1);
    localparam int RW = $clog2(RING_SECS + 1);
    localparam logic [1:0] IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2;

    logic [1:0]    state;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    logic [5:0]    alm_mins  [NUM_ALARMS];
    logic [4:0]    alm_hours [NUM_ALARMS];
    logic          alm_ampm  [NUM_ALARMS];
    logic          alm_en    [NUM_ALARMS];
    logic [5:0]    nxt_secs, nxt_mins;
    logic [4:0]    nxt_hours;
    logic          nxt_ampm, carry, load_t, alm_ok, hit;
    logic [AW-1:0] hit_idx;

    function automatic logic hour_ok(input logic [4:0] h);
        return (HOUR_24 != 0) ? (h <= 5'd23) : (h >= 5'd1 && h <= 5'd12);
    endfunction

    assign load_t   = LoadTime && SetSecs <= 6'd59 && SetMins <= 6'd59 && hour_ok(SetHours);
    assign alm_ok   = LoadAlm && AlarmMinsIn <= 6'd59 && hour_ok(AlarmHoursIn) && int'(AlmSel) < NUM_ALARMS;
    assign Alarm    = state == RINGING;
    assign Snoozing = state == SNOOZE;

    // time one second later, used both for ticking and for alarm matching
    always_comb begin
        carry     = Secs_C == 6'd59 && Mins_C == 6'd59;
        nxt_secs  = (Secs_C == 6'd59) ? 6'd0 : Secs_C + 6'd1;
        nxt_mins  = (Secs_C != 6'd59) ? Mins_C : (Mins_C == 6'd59) ? 6'd0 : Mins_C + 6'd1;
        nxt_hours = !carry ? Hours_C
                  : (HOUR_24 != 0) ? ((Hours_C == 5'd23) ? 5'd0 : Hours_C + 5'd1)
                  : ((Hours_C == 5'd12) ? 5'd1 : Hours_C + 5'd1);
        nxt_ampm  = (HOUR_24 == 0) && (AM_PM ^ (carry && Hours_C == 5'd11));
    end

    // lowest-index enabled slot equal to the incremented time at second zero
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (alm_en[i] && alm_mins[i] == nxt_mins && alm_hours[i] == nxt_hours &&
                (HOUR_24 != 0 || alm_ampm[i] == nxt_ampm)) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        hit = hit && !load_t && nxt_secs == 6'd0;
    end

    // timekeeping: a valid load replaces the tick, otherwise advance one second
    always_ff @(posedge Clock_1Sec) begin
        if (Reset) begin
            Secs_C  <= 6'd0;
            Mins_C  <= 6'd0;
            Hours_C <= (HOUR_24 != 0) ? 5'd0 : 5'd12;
            AM_PM   <= 1'b0;
        end else if (load_t) begin
            Secs_C  <= SetSecs;
            Mins_C  <= SetMins;
            Hours_C <= SetHours;
            AM_PM   <= (HOUR_24 == 0) && Set_AM_PM;
        end else begin
            Secs_C  <= nxt_secs;
            Mins_C  <= nxt_mins;
            Hours_C <= nxt_hours;
            AM_PM   <= nxt_ampm;
        end
    end

    // alarm slot storage; only fully valid writes land
    always_ff @(posedge Clock_1Sec) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_mins[i]  <= 6'd0;
                alm_hours[i] <= 5'd0;
                alm_ampm[i]  <= 1'b0;
                alm_en[i]    <= 1'b0;
            end
        end else if (alm_ok) begin
            alm_mins[AlmSel]  <= AlarmMinsIn;
            alm_hours[AlmSel] <= AlarmHoursIn;
            alm_ampm[AlmSel]  <= (HOUR_24 == 0) && Alarm_AM_PM_In;
            alm_en[AlmSel]    <= AlarmEnIn;
        end
    end

    // ring / snooze controller; stop beats snooze, new matches only start from idle
    always_ff @(posedge Clock_1Sec) begin
        if (Reset) begin
            state    <= IDLE;
            AlarmSrc <= '0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else if (state == IDLE) begin
            if (hit) begin
                state    <= RINGING;
                AlarmSrc <= hit_idx;
                ring_cnt <= '0;
            end
        end else if (state == RINGING) begin
            if (AlarmStop) state <= IDLE;
            else if (Snooze) begin
                state   <= SNOOZE;
                snz_cnt <= SW'(SNZ_LEN);
            end else if (ring_cnt == RW'(RING_SECS - 1)) state <= IDLE;
            else ring_cnt <= ring_cnt + 1'b1;
        end else begin
            if (AlarmStop) state <= IDLE;
            else if (snz_cnt == SW'(1)) begin
                state    <= RINGING;
                ring_cnt <= '0;
            end else snz_cnt <= snz_cnt - 1'b1;
        end
    end
endmodule
